// File: rtl/alu_unit.sv
// alu_unit: registered integer ALU for the execute stage.
//
// The result is formed combinationally from opcode/cc/data_a/data_b and is loaded
// into data_out on every rising clk edge. There is no enable and no handshake.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst_n    - asynchronous active-low reset; clears data_out
//   opcode   - operation select (ADD..CMP = 0..9, others produce 0)
//   cc       - compare condition, only consulted when opcode is CMP
//   data_a   - first operand
//   data_b   - second operand, or unsigned shift amount for shifts
//   data_out - registered result
module alu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode,
  input  logic [2:0]       cc,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_out
);

  // Opcode encodings shared with the decoder.
  localparam logic [4:0] OpAdd = 5'd0;
  localparam logic [4:0] OpSub = 5'd1;
  localparam logic [4:0] OpMpy = 5'd2;
  localparam logic [4:0] OpAnd = 5'd3;
  localparam logic [4:0] OpOr  = 5'd4;
  localparam logic [4:0] OpXor = 5'd5;
  localparam logic [4:0] OpShl = 5'd6;
  localparam logic [4:0] OpSrl = 5'd7;
  localparam logic [4:0] OpSra = 5'd8;
  localparam logic [4:0] OpCmp = 5'd9;

  // Condition codes for CMP.
  localparam logic [2:0] CcEq  = 3'd0;
  localparam logic [2:0] CcNe  = 3'd1;
  localparam logic [2:0] CcLt  = 3'd2;
  localparam logic [2:0] CcLe  = 3'd3;
  localparam logic [2:0] CcUlt = 3'd4;
  localparam logic [2:0] CcUle = 3'd5;

  localparam int unsigned ShW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] WidthVal = WIDTH;

  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] mpy_res;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] sra_res;
  logic [ShW-1:0]   shamt;
  logic             shift_big;
  logic             sign_a;
  logic             eq, slt, ult;
  logic             cmp_res;

  // Arithmetic. The low half of the product is identical for signed and unsigned
  // operands, so a single unsigned multiply serves both.
  always_comb begin
    add_res = data_a + data_b;
    sub_res = data_a - data_b;
    mpy_res = data_a * data_b;
  end

  // Shifts use the full unsigned data_b; any amount >= WIDTH saturates.
  always_comb begin
    shift_big = (data_b >= WidthVal);
    shamt     = data_b[ShW-1:0];
    sign_a    = data_a[WIDTH-1];
    if (shift_big) begin
      shl_res = '0;
      srl_res = '0;
      sra_res = {WIDTH{sign_a}};
    end else begin
      shl_res = data_a << shamt;
      srl_res = data_a >> shamt;
      sra_res = $signed(data_a) >>> shamt;
    end
  end

  // Compare primitives; LE variants are built from LT | EQ.
  always_comb begin
    eq  = (data_a == data_b);
    slt = ($signed(data_a) < $signed(data_b));
    ult = (data_a < data_b);
    case (cc)
      CcEq:    cmp_res = eq;
      CcNe:    cmp_res = ~eq;
      CcLt:    cmp_res = slt;
      CcLe:    cmp_res = slt | eq;
      CcUlt:   cmp_res = ult;
      CcUle:   cmp_res = ult | eq;
      default: cmp_res = 1'b0;
    endcase
  end

  // Result select.
  always_comb begin
    data_out_d = '0;
    case (opcode)
      OpAdd:   data_out_d = add_res;
      OpSub:   data_out_d = sub_res;
      OpMpy:   data_out_d = mpy_res;
      OpAnd:   data_out_d = data_a & data_b;
      OpOr:    data_out_d = data_a | data_b;
      OpXor:   data_out_d = data_a ^ data_b;
      OpShl:   data_out_d = shl_res;
      OpSrl:   data_out_d = srl_res;
      OpSra:   data_out_d = sra_res;
      OpCmp:   data_out_d = {{(WIDTH-1){1'b0}}, cmp_res};
      default: data_out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver pushes hand-computed expected results,
// a monitor pops and compares one clock after each capture edge.
module tb_alu_unit;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, MPY = 5'd2, AND_ = 5'd3, OR_ = 5'd4;
  localparam logic [4:0] XOR_ = 5'd5, SHL = 5'd6, SRL = 5'd7, SRA = 5'd8, CMP = 5'd9;
  localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2, LE = 3'd3, ULT = 3'd4, ULE = 3'd5;

  logic        clk;
  logic        rst_n;
  logic [4:0]  opcode;
  logic [2:0]  cc;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  alu_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .cc       (cc),
    .data_a   (data_a),
    .data_b   (data_b),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: results appear on the edge after the vector was driven.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), data_out, exp_q.pop_front());
    end
  end

  task automatic apply(input string nm, input logic [4:0] op, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    opcode = op;
    cc     = c;
    data_a = a;
    data_b = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cmp6(input string nm, input logic [2:0] c,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    apply(nm, CMP, c, a, b, e);
  endtask

  initial begin
    int budget;
    rst_n  = 1'b0;
    opcode = ADD;
    cc     = EQ;
    data_a = 32'd1;
    data_b = 32'd5;
    #2;
    check("reset_initial", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic
    apply("add_1_5",   ADD, EQ, 32'd1, 32'd5, 32'd6);
    apply("add_m5_8",  ADD, EQ, -32'sd5, 32'd8, 32'd3);
    apply("add_wrap",  ADD, EQ, 32'hFFFF_FFFF, 32'd1, 32'd0);
    apply("sub_8_3",   SUB, EQ, 32'd8, 32'd3, 32'd5);
    apply("sub_0_3",   SUB, EQ, 32'd0, 32'd3, 32'hFFFF_FFFD);
    apply("mpy_8_7",   MPY, EQ, 32'd8, 32'd7, 32'd56);
    apply("mpy_m3_7",  MPY, EQ, -32'sd3, 32'd7, -32'sd21);
    apply("mpy_hi",    MPY, EQ, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
    // Logic; cc is ignored outside CMP
    apply("and_18_7",  AND_, 3'd7, 32'd18, 32'd7, 32'd2);
    apply("or_8_1",    OR_,  EQ, 32'd8, 32'd1, 32'd9);
    apply("xor_9_15",  XOR_, EQ, 32'd9, 32'd15, 32'd6);
    // Shifts
    apply("shl_7_3",   SHL, EQ, 32'd7, 32'd3, 32'd56);
    apply("shl_m4_2",  SHL, EQ, -32'sd4, 32'd2, -32'sd16);
    apply("shl_1_31",  SHL, EQ, 32'd1, 32'd31, 32'h8000_0000);
    apply("shl_1_32",  SHL, EQ, 32'd1, 32'd32, 32'd0);
    apply("srl_34_4",  SRL, EQ, 32'd34, 32'd4, 32'd2);
    apply("srl_m200_4", SRL, EQ, -32'sd200, 32'd4, 32'h0FFF_FFF3);
    apply("srl_big",   SRL, EQ, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0);
    apply("sra_34_2",  SRA, EQ, 32'd34, 32'd2, 32'd8);
    apply("sra_m200_2", SRA, EQ, -32'sd200, 32'd2, -32'sd50);
    apply("sra_m200_255", SRA, EQ, -32'sd200, 32'd255, 32'hFFFF_FFFF);
    apply("sra_pos_40", SRA, EQ, 32'h7FFF_FFFF, 32'd40, 32'd0);
    apply("sra_m1_31", SRA, EQ, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    // Signed compares
    cmp6("eq_4_5",     EQ, 32'd4, 32'd5, 32'd0);
    cmp6("eq_m15",     EQ, -32'sd15, -32'sd15, 32'd1);
    cmp6("eq_m5_0",    EQ, -32'sd5, 32'd0, 32'd0);
    cmp6("eq_0_0",     EQ, 32'd0, 32'd0, 32'd1);
    cmp6("ne_6_m42",   NE, 32'd6, -32'sd42, 32'd1);
    cmp6("ne_0_0",     NE, 32'd0, 32'd0, 32'd0);
    cmp6("ne_128_126", NE, 32'd128, 32'd126, 32'd1);
    cmp6("ne_m5_m5",   NE, -32'sd5, -32'sd5, 32'd0);
    cmp6("lt_7_6",     LT, 32'd7, 32'd6, 32'd0);
    cmp6("lt_6_7",     LT, 32'd6, 32'd7, 32'd1);
    cmp6("lt_m1_88",   LT, -32'sd1, 32'd88, 32'd1);
    cmp6("lt_m2_m9",   LT, -32'sd2, -32'sd9, 32'd0);
    cmp6("lt_14_14",   LT, 32'd14, 32'd14, 32'd0);
    cmp6("le_7_6",     LE, 32'd7, 32'd6, 32'd0);
    cmp6("le_6_7",     LE, 32'd6, 32'd7, 32'd1);
    cmp6("le_m1_88",   LE, -32'sd1, 32'd88, 32'd1);
    cmp6("le_m2_m9",   LE, -32'sd2, -32'sd9, 32'd0);
    cmp6("le_14_14",   LE, 32'd14, 32'd14, 32'd1);
    // Unsigned compares
    cmp6("ult_5_6",    ULT, 32'd5, 32'd6, 32'd1);
    cmp6("ult_6_5",    ULT, 32'd6, 32'd5, 32'd0);
    cmp6("ult_m1_88",  ULT, -32'sd1, 32'd88, 32'd0);
    cmp6("ult_100_m156", ULT, 32'd100, -32'sd156, 32'd1);
    cmp6("ult_5_5",    ULT, 32'd5, 32'd5, 32'd0);
    cmp6("ult_m99",    ULT, -32'sd99, -32'sd99, 32'd0);
    cmp6("ule_5_6",    ULE, 32'd5, 32'd6, 32'd1);
    cmp6("ule_6_5",    ULE, 32'd6, 32'd5, 32'd0);
    cmp6("ule_m1_88",  ULE, -32'sd1, 32'd88, 32'd0);
    cmp6("ule_100_m156", ULE, 32'd100, -32'sd156, 32'd1);
    cmp6("ule_5_5",    ULE, 32'd5, 32'd5, 32'd1);
    cmp6("ule_m99",    ULE, -32'sd99, -32'sd99, 32'd1);
    // Illegal encodings
    apply("op31",      5'd31, EQ, 32'd5, 32'd5, 32'd0);
    apply("op10",      5'd10, EQ, 32'hFFFF_FFFF, 32'd1, 32'd0);
    cmp6("cmp_cc7",    3'd7, 32'd0, 32'd0, 32'd0);
    cmp6("cmp_cc6",    3'd6, 32'd1, 32'd2, 32'd0);

    // Timing: inputs changed mid-cycle must not reach data_out before the edge.
    apply("timing_pre", ADD, EQ, 32'd100, 32'd23, 32'd123);
    @(posedge clk);
    #3;
    opcode = SUB;
    data_a = 32'd50;
    data_b = 32'd8;
    #1;
    check("timing_hold", data_out, 32'd123);
    exp_q.push_back(32'd42);
    name_q.push_back("timing_post");
    @(posedge clk);
    #2;

    // Asynchronous reset asserted mid-cycle, held across an edge.
    check("pre_reset_nonzero", data_out, 32'd42);
    rst_n = 1'b0;
    #1;
    check("reset_async", data_out, 32'd0);
    opcode = ADD;
    data_a = 32'd3;
    data_b = 32'd4;
    @(posedge clk);
    #1;
    check("reset_held", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd7);
    name_q.push_back("reset_release_capture");
    apply("post_reset_xor", XOR_, EQ, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the core's execute stage.
- Implements add, subtract, multiply, bitwise logic, three shifts, and a condition-code-selected compare.
- Result is registered: one clock of latency from operands to data_out.
- Opcode and condition-code encodings are shared with the decoder through the common defines header.

Parameters:
- WIDTH, 32, datapath width of data_a, data_b and data_out.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  5  operation select.
- cc  input  3  condition code; used only when opcode = CMP.
- data_a  input  WIDTH  first operand.
- data_b  input  WIDTH  second operand, or shift amount for shifts.
- data_out  output  WIDTH  registered result.

Behaviour:
- Reset: while rst_n = 0, data_out = 0 immediately (asynchronous), regardless of clk. Reset deasserted mid-stream: the first rising edge after release captures the current inputs normally.
- Latency: result computed combinationally from opcode/cc/data_a/data_b and loaded into data_out on each rising clk edge.
- No enable and no handshake: a new result every cycle.

Opcode encodings:
- ADD=0: data_a + data_b, modulo 2^WIDTH, carry discarded.
- SUB=1: data_a - data_b, modulo 2^WIDTH.
- MPY=2: low WIDTH bits of data_a * data_b. The low half is sign-agnostic.
- AND=3, OR=4, XOR=5: bitwise operations.
- SHL=6: data_a << data_b.
- SRL=7: logical right shift, zero fill.
- SRA=8: arithmetic right shift, sign fill.
- Shift amount is the full unsigned data_b. Amount >= WIDTH gives:
  - 0 for SHL and SRL;
  - all copies of data_a's sign bit for SRA.
- CMP=9: data_out = 1 if the condition holds, else 0 (upper bits zero).
- Opcodes 10..31: data_out = 0.

Condition codes (CMP only):
- EQ=0: a == b.
- NE=1: a != b.
- LT=2: signed a < b.
- LE=3: signed a <= b.
- ULT=4: unsigned a < b.
- ULE=5: unsigned a <= b.
- cc 6,7: result 0.
- cc is ignored for all non-CMP opcodes.

Signedness:
- Signed compares use two's complement, so -1 < 88 is true.
- Unsigned compares treat the operands as raw bits, so 0xFFFFFFFF < 88 is false.

Test Plan:
- Reset and arithmetic:
  - Assert rst_n = 0 mid-cycle -> data_out = 0 immediately.
  - Release reset; ADD 1,5 -> 6 after one edge.
  - ADD -5,8 -> 3.
  - SUB 8,3 -> 5; SUB 0,3 -> 0xFFFFFFFD.
  - MPY 8,7 -> 56.
- Logic: AND 18,7 -> 2; OR 8,1 -> 9; XOR 9,15 -> 6.
- Shifts:
  - SHL 7,3 -> 56; SHL -4,2 -> -16.
  - SRL 34,4 -> 2; SRL -200,4 -> 0x0FFFFFF3.
  - SRA 34,2 -> 8; SRA -200,2 -> -50; SRA -200,255 -> 0xFFFFFFFF.
- Signed compares:
  - EQ: (4,5) -> 0; (-15,-15) -> 1; (-5,0) -> 0; (0,0) -> 1.
  - NE: (6,-42) -> 1; (0,0) -> 0; (128,126) -> 1; (-5,-5) -> 0.
  - LT: (7,6) -> 0; (6,7) -> 1; (-1,88) -> 1; (-2,-9) -> 0; (14,14) -> 0.
  - LE: same operand pairs -> 0, 1, 1, 0, 1.
- Unsigned compares:
  - ULT: (5,6) -> 1; (6,5) -> 0; (-1,88) -> 0; (100,-156) -> 1; (5,5) -> 0; (-99,-99) -> 0.
  - ULE: same operand pairs -> 1, 0, 0, 1, 1, 1.
- Illegal encodings and timing:
  - Opcode 31 -> 0.
  - CMP with cc = 7 -> 0.
  - Inputs changed between edges -> data_out changes only at the rising edge.
